// File: rtl/mul_div_unit.sv
// mul_div_unit: EX-stage multiply/divide unit with HI/LO registers; define MDU_MADD_EN to enable madd/maddu
module mul_div_unit #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [3:0]  md_op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic        busy,
    output logic [31:0] hi,
    output logic [31:0] lo
);
    localparam logic [3:0] OP_MULT  = 4'd1;
    localparam logic [3:0] OP_MULTU = 4'd2;
    localparam logic [3:0] OP_DIV   = 4'd3;
    localparam logic [3:0] OP_DIVU  = 4'd4;
    localparam logic [3:0] OP_MTHI  = 4'd5;
    localparam logic [3:0] OP_MTLO  = 4'd6;
    localparam logic [3:0] OP_MADD  = 4'd7;
    localparam logic [3:0] OP_MADDU = 4'd8;
    localparam int MAXC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CW   = (MAXC > 1) ? $clog2(MAXC) : 1;

    typedef enum logic {IDLE, RUN} state_t;

    state_t        state, state_n;
    logic [CW-1:0] cnt;
    logic [3:0]    rop;
    logic [31:0]   ra, rb;
    logic          is_mul, is_div, accept, commit, sgn, rdiv, wr;
    logic [63:0]   prod, res;
    logic [31:0]   ua, ub, q, r;

    // decode the incoming op and sequence IDLE -> RUN -> IDLE
    always_comb begin
        is_div = md_op == OP_DIV || md_op == OP_DIVU;
`ifdef MDU_MADD_EN
        is_mul = md_op == OP_MULT || md_op == OP_MULTU || md_op == OP_MADD || md_op == OP_MADDU;
`else
        is_mul = md_op == OP_MULT || md_op == OP_MULTU;
`endif
        accept  = state == IDLE && start && (is_mul || is_div);
        commit  = state == RUN && cnt == '0;
        state_n = accept ? RUN : (commit ? IDLE : state);
    end

    // result from the captured operands; division works on magnitudes so the
    // 0x80000000 / -1 case wraps instead of overflowing
    always_comb begin
        sgn  = rop == OP_MULT || rop == OP_DIV || rop == OP_MADD;
        rdiv = rop == OP_DIV || rop == OP_DIVU;
        prod = sgn ? {{32{ra[31]}}, ra} * {{32{rb[31]}}, rb} : {32'd0, ra} * {32'd0, rb};
        ua   = (sgn && ra[31]) ? -ra : ra;
        ub   = (sgn && rb[31]) ? -rb : rb;
        q    = (ub == '0) ? '0 : ua / ub;
        r    = (ub == '0) ? '0 : ua % ub;
        wr   = !(rdiv && rb == '0);
`ifdef MDU_MADD_EN
        res  = rdiv ? {(sgn && ra[31]) ? -r : r, (sgn && (ra[31] ^ rb[31])) ? -q : q} :
               (rop == OP_MADD || rop == OP_MADDU) ? prod + {hi, lo} : prod;
`else
        res  = rdiv ? {(sgn && ra[31]) ? -r : r, (sgn && (ra[31] ^ rb[31])) ? -q : q} : prod;
`endif
    end

    // state register
    always_ff @(posedge clk) begin
        if (reset)
            state <= IDLE;
        else
            state <= state_n;
    end

    // operand capture, countdown and HI/LO writes
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt <= '0;
            rop <= '0;
            ra  <= '0;
            rb  <= '0;
            hi  <= '0;
            lo  <= '0;
        end else begin
            if (accept) begin
                rop <= md_op;
                ra  <= a;
                rb  <= b;
                cnt <= is_mul ? CW'(MULT_CYCLES - 1) : CW'(DIV_CYCLES - 1);
            end else if (state == RUN && !commit)
                cnt <= cnt - CW'(1);
            if (commit && wr) begin
                hi <= res[63:32];
                lo <= res[31:0];
            end else if (state == IDLE && start && md_op == OP_MTHI)
                hi <= a;
            else if (state == IDLE && start && md_op == OP_MTLO)
                lo <= a;
        end
    end

    assign busy = state == RUN;
endmodule

// File: tb/tb_mul_div_unit.sv
// tb_mul_div_unit: table-driven and scoreboard bench for mul_div_unit
module tb_mul_div_unit;
    logic        clk = 1'b0;
    logic        reset, start, busy;
    logic [3:0]  md_op;
    logic [31:0] a, b, hi, lo;

    typedef struct {
        logic [3:0]  op;
        logic [31:0] a, b, eh, el;
        int          lat;
    } vec_t;

    vec_t        tv[15];
    logic [63:0] sb[$];
    int          n_chk = 0, n_bad = 0;
    logic [31:0] cur_hi, cur_lo;

    always #5 clk = ~clk;

    mul_div_unit dut (
        .clk(clk), .reset(reset), .start(start), .md_op(md_op),
        .a(a), .b(b), .busy(busy), .hi(hi), .lo(lo)
    );

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // issue one op, push its expected HI/LO, then pop and compare when it finishes
    task automatic run(input logic [3:0] op, input logic [31:0] va, input logic [31:0] vb,
                       input logic [31:0] eh, input logic [31:0] el, input int lat);
        int n;
        logic [63:0] e;
        @(negedge clk);
        start = 1'b1; md_op = op; a = va; b = vb;
        sb.push_back({eh, el});
        @(negedge clk);
        start = 1'b0; md_op = 4'd0;
        n = 0;
        while (busy && n < 100) begin
            n++;
            chk("hold", {hi, lo}, {cur_hi, cur_lo});
            @(negedge clk);
        end
        chk("latency", 64'(n), 64'(lat));
        e = sb.pop_front();
        chk("result", {hi, lo}, e);
        cur_hi = e[63:32];
        cur_lo = e[31:0];
    endtask

    function automatic logic [63:0] model(input logic [3:0] op, input logic [31:0] x, input logic [31:0] y,
                                          input logic [31:0] h, input logic [31:0] l);
        longint sx, sy, qq, rr;
        sx = longint'($signed(x));
        sy = longint'($signed(y));
        if (op == 4'd1) return 64'(sx * sy);
        if (op == 4'd2) return {32'd0, x} * {32'd0, y};
        if (y == 32'd0) return {h, l};
        if (op == 4'd3) begin
            qq = sx / sy;
            rr = sx % sy;
            return {rr[31:0], qq[31:0]};
        end
        return {x % y, x / y};
    endfunction

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int n;
        logic saw;
        logic [3:0] op;
        logic [31:0] ra, rb;
        logic [63:0] e;
        tv[0]  = '{4'd5, 32'h12345678, 32'h0,        32'h12345678, 32'h00000000, 0};
        tv[1]  = '{4'd6, 32'h9ABCDEF0, 32'h0,        32'h12345678, 32'h9ABCDEF0, 0};
        tv[2]  = '{4'd1, 32'h3,        32'hFFFFFFFE, 32'hFFFFFFFF, 32'hFFFFFFFA, 5};
        tv[3]  = '{4'd2, 32'h3,        32'hFFFFFFFE, 32'h00000002, 32'hFFFFFFFA, 5};
        tv[4]  = '{4'd3, 32'hFFFFFFF9, 32'h2,        32'hFFFFFFFF, 32'hFFFFFFFD, 10};
        tv[5]  = '{4'd4, 32'h7,        32'h2,        32'h00000001, 32'h00000003, 10};
        tv[6]  = '{4'd5, 32'hAA,       32'h0,        32'h000000AA, 32'h00000003, 0};
        tv[7]  = '{4'd6, 32'hBB,       32'h0,        32'h000000AA, 32'h000000BB, 0};
        tv[8]  = '{4'd3, 32'h5,        32'h0,        32'h000000AA, 32'h000000BB, 10};
        tv[9]  = '{4'd4, 32'h9,        32'h0,        32'h000000AA, 32'h000000BB, 10};
        tv[10] = '{4'd3, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 10};
        tv[11] = '{4'd0, 32'h55,       32'h66,       32'h00000000, 32'h80000000, 0};
        tv[12] = '{4'd9, 32'h55,       32'h66,       32'h00000000, 32'h80000000, 0};
        tv[13] = '{4'd1, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, 5};
        tv[14] = '{4'd3, 32'h7,        32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD, 10};

        reset = 1'b1; start = 1'b0; md_op = 4'd0; a = '0; b = '0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        chk("reset_busy", 64'(busy), 64'd0);
        chk("reset_hilo", {hi, lo}, 64'd0);
        cur_hi = '0;
        cur_lo = '0;

        for (int i = 0; i < 15; i++)
            run(tv[i].op, tv[i].a, tv[i].b, tv[i].eh, tv[i].el, tv[i].lat);

        // reset during busy cycle 3 aborts the mult with no later write
        @(negedge clk);
        start = 1'b1; md_op = 4'd1; a = 32'd3; b = 32'd4;
        @(negedge clk);
        start = 1'b0; md_op = 4'd0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("abort_busy", 64'(busy), 64'd0);
        chk("abort_hilo", {hi, lo}, 64'd0);
        saw = 1'b0;
        repeat (10) begin
            @(negedge clk);
            saw = saw | busy;
        end
        chk("abort_no_busy", 64'(saw), 64'd0);
        chk("abort_no_write", {hi, lo}, 64'd0);
        cur_hi = '0;
        cur_lo = '0;

        // a second start during busy cycle 2 must be ignored
        @(negedge clk);
        start = 1'b1; md_op = 4'd1; a = 32'd2; b = 32'd3;
        sb.push_back({32'd0, 32'd6});
        @(negedge clk);
        start = 1'b0; md_op = 4'd0;
        n = 0;
        while (busy && n < 100) begin
            n++;
            start = (n == 2);
            md_op = (n == 2) ? 4'd1 : 4'd0;
            a = 32'd5; b = 32'd5;
            @(negedge clk);
        end
        start = 1'b0; md_op = 4'd0;
        chk("ignore_latency", 64'(n), 64'd5);
        e = sb.pop_front();
        chk("ignore_result", {hi, lo}, e);
        saw = 1'b0;
        repeat (8) begin
            @(negedge clk);
            saw = saw | busy;
        end
        chk("ignore_no_busy", 64'(saw), 64'd0);
        chk("ignore_hold", {hi, lo}, e);
        cur_hi = e[63:32];
        cur_lo = e[31:0];

`ifdef MDU_MADD_EN
        run(4'd5, 32'h0, 32'h0, 32'h0, cur_lo, 0);
        run(4'd6, 32'hFFFFFFFF, 32'h0, 32'h0, 32'hFFFFFFFF, 0);
        run(4'd8, 32'h1, 32'h1, 32'h1, 32'h0, 5);
        run(4'd7, 32'hFFFFFFFF, 32'h1, 32'h0, 32'hFFFFFFFF, 5);
`else
        run(4'd7, 32'h5, 32'h5, cur_hi, cur_lo, 0);
        run(4'd8, 32'h5, 32'h5, cur_hi, cur_lo, 0);
`endif

        for (int i = 0; i < 8; i++) begin
            op = 4'($urandom_range(1, 4));
            ra = $urandom;
            rb = (i == 3) ? 32'd0 : (($urandom_range(0, 1) == 0) ? 32'($urandom_range(1, 20)) : $urandom);
            e  = model(op, ra, rb, cur_hi, cur_lo);
            run(op, ra, rb, e[63:32], e[31:0], (op <= 4'd2) ? 5 : 10);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_bad);
        $finish;
    end
endmodule
